l2_port_scheduler: RTL

- Three-requester scheduler in front of the single L2/pmem port: i-cache fill (read), d-cache fill/writeback (read/write), and next-line prefetcher (read).
- Grants one outstanding line transaction at a time with rotating priority and optional demand-over-prefetch priority.
- Latches the granted request, drives the pmem handshake, and returns one registered line plus a one-cycle response pulse to the winner.
- Includes a sticky watchdog flag for a stalled pmem.

---
 rtl/l2_sched_pkg.sv | 24 ++
 rtl/l2_port_scheduler_if.sv | 40 ++++
 rtl/l2_port_scheduler_rr_pick.sv | 31 +++
 rtl/l2_port_scheduler.sv | 128 ++++++++++++
 4 files changed

// File: rtl/l2_sched_pkg.sv
// Shared types for the L2 port scheduler: FSM states, requester ids, latched transaction header.
package l2_sched_pkg;

   localparam int unsigned NUM_REQ = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      REQ_I    = 2'd0,
      REQ_D    = 2'd1,
      REQ_P    = 2'd2,
      REQ_NONE = 2'd3
   } req_id_t;

   typedef struct packed {
      logic        write;
      logic [31:0] addr;
   } txn_t;

endpackage

// File: rtl/l2_port_scheduler_if.sv
// Signal bundle between the three requesters, the scheduler and the pmem port.
// slave is the scheduler's view; master is the requesters plus the L2 side.
interface l2_port_scheduler_if #(
   parameter int unsigned s_line = 256
);
   logic              req_i_read;
   logic [31:0]       req_i_addr;
   logic              resp_i;
   logic              req_d_read;
   logic              req_d_write;
   logic [31:0]       req_d_addr;
   logic [s_line-1:0] req_d_wdata;
   logic              resp_d;
   logic              req_p_read;
   logic [31:0]       req_p_addr;
   logic              resp_p;
   logic [s_line-1:0] line_rdata;
   logic              pmem_read;
   logic              pmem_write;
   logic [31:0]       pmem_addr;
   logic [s_line-1:0] pmem_wdata;
   logic              pmem_resp;
   logic [s_line-1:0] pmem_rdata;
   logic [1:0]        grant_id;
   logic              timeout_err;

   modport slave (
      input  req_i_read, req_i_addr, req_d_read, req_d_write, req_d_addr, req_d_wdata,
             req_p_read, req_p_addr, pmem_resp, pmem_rdata,
      output resp_i, resp_d, resp_p, line_rdata, pmem_read, pmem_write, pmem_addr,
             pmem_wdata, grant_id, timeout_err
   );

   modport master (
      output req_i_read, req_i_addr, req_d_read, req_d_write, req_d_addr, req_d_wdata,
             req_p_read, req_p_addr, pmem_resp, pmem_rdata,
      input  resp_i, resp_d, resp_p, line_rdata, pmem_read, pmem_write, pmem_addr,
             pmem_wdata, grant_id, timeout_err
   );
endinterface

// File: rtl/l2_port_scheduler_rr_pick.sv
// Combinational rotating-priority picker: first requester after last_grant in order I->D->P->I.
module l2_port_scheduler_rr_pick
   import l2_sched_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  req_id_t            last_grant,
   input  logic               pf_low,
   output req_id_t            winner,
   output logic               valid
);

   logic [NUM_REQ-1:0] eff;
   logic [1:0]         idx;

   always_comb begin
      eff = req;
      // Prefetch yields to any demand request when pf_low is set.
      if (pf_low && (req[0] || req[1])) eff[2] = 1'b0;
      idx    = (last_grant == REQ_NONE) ? 2'(REQ_P) : 2'(last_grant);
      winner = REQ_NONE;
      valid  = 1'b0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
         if (!valid && eff[idx]) begin
            valid  = 1'b1;
            winner = req_id_t'(idx);
         end
      end
   end

endmodule

// File: rtl/l2_port_scheduler.sv
// Single-outstanding scheduler for the L2/pmem port shared by i-cache, d-cache and prefetcher.
module l2_port_scheduler
   import l2_sched_pkg::*;
#(
   parameter int unsigned s_line      = 256,
   parameter int unsigned s_offset    = 5,
   parameter int unsigned TIMEOUT_CYC = 1024,
   parameter bit          PF_LOW      = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   l2_port_scheduler_if.slave  bus
);

   localparam int unsigned      WD_W     = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT_CYC);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
   localparam logic [31:0]      OFF_MASK = ~((32'd1 << s_offset) - 32'd1);

   state_t             state;
   req_id_t            last_grant;
   req_id_t            grant_q;
   txn_t               txn_q;
   logic [s_line-1:0]  wdata_q;
   logic [s_line-1:0]  line_q;
   logic               pmem_read_q;
   logic               pmem_write_q;
   logic               resp_i_q;
   logic               resp_d_q;
   logic               resp_p_q;
   logic               timeout_q;
   logic [WD_W-1:0]    wd_cnt;

   logic [NUM_REQ-1:0] req_vec;
   req_id_t            pick_id;
   logic               pick_valid;
   txn_t               pick_txn;

   assign req_vec = {bus.req_p_read, bus.req_d_read | bus.req_d_write, bus.req_i_read};

   l2_port_scheduler_rr_pick u_rr_pick (
      .req        (req_vec),
      .last_grant (last_grant),
      .pf_low     (PF_LOW),
      .winner     (pick_id),
      .valid      (pick_valid)
   );

   // Header of the winning request; a D request with write high is a write regardless of read.
   always_comb begin
      pick_txn = '0;
      case (pick_id)
         REQ_I:   pick_txn = '{write: 1'b0,            addr: bus.req_i_addr & OFF_MASK};
         REQ_D:   pick_txn = '{write: bus.req_d_write, addr: bus.req_d_addr & OFF_MASK};
         REQ_P:   pick_txn = '{write: 1'b0,            addr: bus.req_p_addr & OFF_MASK};
         default: pick_txn = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         last_grant   <= REQ_P;
         grant_q      <= REQ_NONE;
         txn_q        <= '0;
         wdata_q      <= '0;
         line_q       <= '0;
         pmem_read_q  <= 1'b0;
         pmem_write_q <= 1'b0;
         resp_i_q     <= 1'b0;
         resp_d_q     <= 1'b0;
         resp_p_q     <= 1'b0;
         timeout_q    <= 1'b0;
         wd_cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  txn_q        <= pick_txn;
                  wdata_q      <= bus.req_d_wdata;
                  pmem_read_q  <= !pick_txn.write;
                  pmem_write_q <= pick_txn.write;
                  grant_q      <= pick_id;
                  last_grant   <= pick_id;
                  state        <= BUSY;
               end else begin
                  grant_q <= REQ_NONE;
               end
            end
            BUSY: begin
               if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + WD_W'(1);
               // Sticky flag set at the end of the TIMEOUT_CYC-th BUSY cycle; transfer continues.
               if (TIMEOUT_CYC != 0 && wd_cnt == WD_LAST) timeout_q <= 1'b1;
               if (bus.pmem_resp) begin
                  if (!txn_q.write) line_q <= bus.pmem_rdata;
                  pmem_read_q  <= 1'b0;
                  pmem_write_q <= 1'b0;
                  wd_cnt       <= '0;
                  resp_i_q     <= (grant_q == REQ_I);
                  resp_d_q     <= (grant_q == REQ_D);
                  resp_p_q     <= (grant_q == REQ_P);
                  state        <= DONE;
               end
            end
            DONE: begin
               resp_i_q <= 1'b0;
               resp_d_q <= 1'b0;
               resp_p_q <= 1'b0;
               grant_q  <= REQ_NONE;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.resp_i      = resp_i_q;
   assign bus.resp_d      = resp_d_q;
   assign bus.resp_p      = resp_p_q;
   assign bus.line_rdata  = line_q;
   assign bus.pmem_read   = pmem_read_q;
   assign bus.pmem_write  = pmem_write_q;
   assign bus.pmem_addr   = txn_q.addr;
   assign bus.pmem_wdata  = wdata_q;
   assign bus.grant_id    = grant_q;
   assign bus.timeout_err = timeout_q;

endmodule
